effect_sequencer: RTL and testbench

//  Sequences audio samples between the effects controller (sample source/sink) and a bank of

---
 rtl/effect_ctrl_pkg.sv | 24 ++
 rtl/fx_watchdog.sv | 37 +++
 rtl/effect_sequencer.sv | 170 +++++++++++++++++
 tb/tb_effect_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/effect_ctrl_pkg.sv
// Shared state encoding, select constants and defaults for the effect sequencer
// and the effect_module wrapper that instantiates it.
package effect_ctrl_pkg;

    localparam int D_WIDTH_DEFAULT = 16;
    localparam int SEL_W           = 2;

    localparam logic [SEL_W-1:0] FX_BYPASS = 2'd0;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DISPATCH,
        WAIT_FX,
        OUTPUT
    } state_e;

    // Selections naming a core that does not exist fall back to bypass.
    function automatic logic [SEL_W-1:0] sanitize_sel(input logic [SEL_W-1:0] sw_v,
                                                      input int              n_fx);
        return (int'(sw_v) > n_fx) ? FX_BYPASS : sw_v;
    endfunction

endpackage

// File: rtl/fx_watchdog.sv
// Cycle counter guarding an effect core; expired_o is high while the count sits
// at TIMEOUT-1, i.e. on the TIMEOUT-th enabled cycle after a clear.
module fx_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/effect_sequencer.sv
// Moves one sample at a time from the source, through the selected effect core
// (or straight through on bypass), to the sink; every output is a register.
module effect_sequencer
    import effect_ctrl_pkg::*;
#(
    parameter int d_width = D_WIDTH_DEFAULT,
    parameter int N_FX    = 3,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SEL_W-1:0]        sw,
    input  logic                    i_data_ready,
    input  logic [d_width-1:0]      i_data,
    output logic                    o_read_enable,
    input  logic                    i_read_done,
    output logic [d_width-1:0]      fx_o_data,
    output logic [N_FX-1:0]         fx_o_start,
    input  logic [N_FX-1:0]         fx_i_done,
    input  logic [N_FX*d_width-1:0] fx_i_data,
    output logic [d_width-1:0]      o_data,
    output logic                    o_data_valid,
    input  logic                    i_out_ready,
    output logic [SEL_W-1:0]        o_active_fx,
    output logic                    o_timeout
);

    state_e               state_q,   state_d;
    logic [SEL_W-1:0]     sel_q,     sel_d;
    logic [d_width-1:0]   sample_q,  sample_d;
    logic [d_width-1:0]   result_q,  result_d;
    logic                 valid_q,   valid_d;
    logic                 rd_en_q,   rd_en_d;
    logic [N_FX-1:0]      start_q,   start_d;
    logic                 timeout_q, timeout_d;

    logic                 wd_clear;
    logic                 wd_enable;
    logic                 wd_expired;

    logic                 sel_done;
    logic [d_width-1:0]   sel_result;
    logic [N_FX-1:0]      sel_onehot;

    fx_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Only the latched core is looked at; done pulses from the others never reach the FSM.
    always_comb begin
        sel_done   = 1'b0;
        sel_result = '0;
        sel_onehot = '0;
        for (int k = 0; k < N_FX; k++) begin
            if (int'(sel_q) == k + 1) begin
                sel_done      = fx_i_done[k];
                sel_result    = fx_i_data[k*d_width +: d_width];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // NOTE: every _d starts from its _q (or a constant) so no branch can infer a latch.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        sample_d  = sample_q;
        result_d  = result_q;
        valid_d   = valid_q;
        rd_en_d   = rd_en_q;
        start_d   = '0;
        timeout_d = timeout_q;
        wd_clear  = 1'b0;
        wd_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_data_ready) begin
                    sel_d   = sanitize_sel(sw, N_FX);
                    rd_en_d = 1'b1;
                    state_d = READ;
                end
            end

            READ: begin
                if (i_read_done) begin
                    rd_en_d  = 1'b0;
                    sample_d = i_data;
                    if (sel_q == FX_BYPASS) begin
                        result_d = i_data;
                        valid_d  = 1'b1;
                        state_d  = OUTPUT;
                    end else begin
                        start_d = sel_onehot;
                        state_d = DISPATCH;
                    end
                end
            end

            DISPATCH: begin
                wd_clear = 1'b1;
                state_d  = WAIT_FX;
            end

            WAIT_FX: begin
                wd_enable = 1'b1;
                // A result landing on the last allowed cycle still beats the watchdog.
                if (sel_done) begin
                    result_d = sel_result;
                    valid_d  = 1'b1;
                    state_d  = OUTPUT;
                end else if (wd_expired) begin
                    result_d  = sample_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = OUTPUT;
                end
            end

            OUTPUT: begin
                if (i_out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset clears every register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= FX_BYPASS;
            sample_q  <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            start_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            sample_q  <= sample_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            rd_en_q   <= rd_en_d;
            start_q   <= start_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_read_enable = rd_en_q;
    assign fx_o_data     = sample_q;
    assign fx_o_start    = start_q;
    assign o_data        = result_q;
    assign o_data_valid  = valid_q;
    assign o_active_fx   = sel_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// Self-checking bench for effect_sequencer: directed scenarios plus randomized
// samples, each judged against a per-sample model of the expected result.
module tb_effect_sequencer;

    localparam int DW  = 16;
    localparam int NFX = 3;
    localparam int TO  = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        sw;
    logic              i_data_ready;
    logic [DW-1:0]     i_data;
    logic              o_read_enable;
    logic              i_read_done;
    logic [DW-1:0]     fx_o_data;
    logic [NFX-1:0]    fx_o_start;
    logic [NFX-1:0]    fx_i_done;
    logic [NFX*DW-1:0] fx_i_data;
    logic [DW-1:0]     o_data;
    logic              o_data_valid;
    logic              i_out_ready;
    logic [1:0]        o_active_fx;
    logic              o_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit to_seen = 1'b0;

    always #5 clk = ~clk;

    effect_sequencer #(
        .d_width (DW),
        .N_FX    (NFX),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sw            (sw),
        .i_data_ready  (i_data_ready),
        .i_data        (i_data),
        .o_read_enable (o_read_enable),
        .i_read_done   (i_read_done),
        .fx_o_data     (fx_o_data),
        .fx_o_start    (fx_o_start),
        .fx_i_done     (fx_i_done),
        .fx_i_data     (fx_i_data),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .i_out_ready   (i_out_ready),
        .o_active_fx   (o_active_fx),
        .o_timeout     (o_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Randomises everything the DUT must ignore in the current state.
    task automatic drive_noise(input logic [1:0] sel, input int stray, input int sw_noise);
        for (int c = 0; c < NFX; c++) begin
            fx_i_data[c*DW +: DW] = DW'($urandom);
            if (c == int'(sel) - 1)  fx_i_done[c] = 1'b0;
            else if (stray == 2)     fx_i_done[c] = 1'b1;
            else if (stray == 1)     fx_i_done[c] = 1'($urandom_range(0, 1));
            else                     fx_i_done[c] = 1'b0;
        end
        i_read_done = 1'($urandom_range(0, 1));
        i_data      = DW'($urandom);
        if (sw_noise >= 4)      sw = 2'($urandom_range(0, 3));
        else if (sw_noise >= 0) sw = 2'(sw_noise);
    endtask

    // One complete sample. delay = cycle after the start pulse in which the core answers
    // (anything outside 1..TO means the core is too late and the dry sample is expected).
    task automatic run_sample(input logic [1:0] sw_v, input logic [DW-1:0] data,
                              input int rd_delay, input int delay, input logic [DW-1:0] result,
                              input int hold, input int stray, input int sw_noise);
        logic [1:0]     sel;
        logic [NFX-1:0] onehot;
        logic [DW-1:0]  exp;
        bit             acc;
        bit             rd_ok, act_ok, dry_ok, hold_ok;
        int             v, first_v, extra_start;

        sel = (int'(sw_v) > NFX) ? 2'd0 : sw_v;
        for (int k = 0; k < NFX; k++) onehot[k] = (int'(sel) == k + 1);
        acc = (delay >= 1) && (delay <= TO);
        exp = (sel == 2'd0) ? data : (acc ? result : data);

        sw = sw_v;
        i_data_ready = 1'b1;
        tick();
        i_data_ready = 1'b0;
        total++;
        if (o_read_enable !== 1'b1 || o_active_fx !== sel || o_data_valid !== 1'b0 || fx_o_start !== '0) begin
            bad++;
            $display("FAIL read_start: rd_en=%b active=%0d valid=%b start=%b, want 1 %0d 0 000",
                     o_read_enable, o_active_fx, o_data_valid, fx_o_start, sel);
        end

        rd_ok = 1'b1;
        for (int j = 0; j < rd_delay; j++) begin
            if (sw_noise >= 0) sw = 2'($urandom_range(0, 3));
            tick();
            if (o_read_enable !== 1'b1 || o_active_fx !== sel) rd_ok = 1'b0;
        end
        i_read_done = 1'b1;
        i_data      = data;
        tick();
        i_read_done = 1'b0;
        i_data      = DW'($urandom);
        total++;
        if (!rd_ok) begin
            bad++;
            $display("FAIL read_hold: read_enable or selection dropped while waiting for read_done");
        end
        total++;
        if (o_read_enable !== 1'b0 || fx_o_data !== data) begin
            bad++;
            $display("FAIL capture: rd_en=%b fx_o_data=%h, want 0 %h", o_read_enable, fx_o_data, data);
        end

        if (sel == 2'd0) begin
            total++;
            if (o_data_valid !== 1'b1 || o_data !== data || fx_o_start !== '0) begin
                bad++;
                $display("FAIL bypass_out: valid=%b data=%h start=%b, want 1 %h 000",
                         o_data_valid, o_data, fx_o_start, data);
            end
        end else begin
            total++;
            if (fx_o_start !== onehot || o_data_valid !== 1'b0) begin
                bad++;
                $display("FAIL start_pulse: start=%b valid=%b, want %b 0", fx_o_start, o_data_valid, onehot);
            end
            v = acc ? delay + 1 : TO + 1;
            first_v = -1;
            extra_start = 0;
            act_ok = 1'b1;
            dry_ok = 1'b1;
            for (int k = 1; k <= v; k++) begin
                tick();
                if (o_data_valid === 1'b1 && first_v < 0) first_v = k;
                if (fx_o_start !== '0) extra_start++;
                if (o_active_fx !== sel) act_ok = 1'b0;
                if (fx_o_data !== data) dry_ok = 1'b0;
                drive_noise(sel, stray, sw_noise);
                if (k == delay) begin
                    fx_i_done[int'(sel) - 1] = 1'b1;
                    fx_i_data[(int'(sel) - 1)*DW +: DW] = result;
                end
            end
            if (!acc) to_seen = 1'b1;
            total++;
            if (first_v != v) begin
                bad++;
                $display("FAIL fx_latency: valid first seen at cycle %0d after start, want %0d", first_v, v);
            end
            total++;
            if (extra_start != 0) begin
                bad++;
                $display("FAIL start_single: %0d extra start cycles, want 0", extra_start);
            end
            total++;
            if (!act_ok || !dry_ok) begin
                bad++;
                $display("FAIL inflight_stable: active_ok=%b dry_ok=%b, want 1 1", act_ok, dry_ok);
            end
            total++;
            if (o_data !== exp) begin
                bad++;
                $display("FAIL fx_result: o_data=%h, want %h", o_data, exp);
            end
        end

        total++;
        if (o_timeout !== to_seen) begin
            bad++;
            $display("FAIL timeout_flag: o_timeout=%b, want %b", o_timeout, to_seen);
        end

        hold_ok = 1'b1;
        for (int j = 0; j < hold; j++) begin
            drive_noise(sel, stray, sw_noise);
            if (sel != 2'd0) fx_i_done[int'(sel) - 1] = 1'($urandom_range(0, 1));
            tick();
            if (o_data_valid !== 1'b1 || o_data !== exp || o_active_fx !== sel) hold_ok = 1'b0;
        end
        total++;
        if (!hold_ok) begin
            bad++;
            $display("FAIL output_hold: valid/data/active changed while sink stalled (data=%h want %h)",
                     o_data, exp);
        end

        fx_i_done   = '0;
        i_read_done = 1'b0;
        i_out_ready = 1'b1;
        tick();
        i_out_ready = 1'b0;
        total++;
        if (o_data_valid !== 1'b0 || o_read_enable !== 1'b0 || fx_o_start !== '0) begin
            bad++;
            $display("FAIL release: valid=%b rd_en=%b start=%b, want 0 0 000",
                     o_data_valid, o_read_enable, fx_o_start);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_data_ready = 1'b1;
        sw = 2'd1;
        tick();
        tick();
        total++;
        if ({o_read_enable, fx_o_start, o_data_valid, o_active_fx, o_timeout, o_data, fx_o_data} !== '0) begin
            bad++;
            $display("FAIL reset_state: rd_en=%b start=%b valid=%b active=%0d to=%b data=%h dry=%h, want all 0",
                     o_read_enable, fx_o_start, o_data_valid, o_active_fx, o_timeout, o_data, fx_o_data);
        end
        i_data_ready = 1'b0;
        reset = 1'b0;
        to_seen = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        run_sample(2'd0, 16'h1234, 2, 0, 16'h0000, 3, 0, -1);
    endtask

    task automatic test_effect1();
        run_sample(2'd1, 16'h0400, 0, 5, 16'h00f0, 1, 0, -1);
    endtask

    task automatic test_back_to_back();
        int start_cyc;
        start_cyc = cyc;
        for (int n = 0; n < 4; n++) run_sample(2'd0, DW'($urandom), 0, 0, 16'h0, 0, 0, -1);
        total++;
        if (cyc - start_cyc != 12) begin
            bad++;
            $display("FAIL throughput: 4 bypass samples took %0d cycles, want 12", cyc - start_cyc);
        end
    endtask

    task automatic test_stray_done();
        run_sample(2'd1, 16'hbeef, 1, 6, 16'h5a5a, 2, 2, -1);
        run_sample(2'd1, 16'h7001, 0, TO, 16'h0c0c, 1, 1, -1);
    endtask

    task automatic test_sw_toggle();
        run_sample(2'd1, 16'h1111, 1, 4, 16'h2222, 3, 1, 3);
        run_sample(2'd3, 16'h3333, 0, 2, 16'h4444, 1, 1, -1);
    endtask

    task automatic test_timeout();
        run_sample(2'd2, 16'h0abc, 0, TO + 1, 16'hdead, 3, 1, -1);
        run_sample(2'd0, 16'h0001, 0, 0, 16'h0, 1, 0, -1);
        run_sample(2'd3, 16'h0002, 1, 3, 16'h0003, 0, 1, -1);
    endtask

    task automatic test_reset_in_wait();
        bit quiet;
        sw = 2'd2;
        i_data_ready = 1'b1;
        tick();
        i_data_ready = 1'b0;
        i_read_done = 1'b1;
        i_data = 16'h6789;
        tick();
        i_read_done = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        to_seen = 1'b0;
        total++;
        if ({o_read_enable, fx_o_start, o_data_valid, o_active_fx, o_timeout, o_data, fx_o_data} !== '0) begin
            bad++;
            $display("FAIL reset_wait: rd_en=%b start=%b valid=%b active=%0d to=%b data=%h dry=%h, want all 0",
                     o_read_enable, fx_o_start, o_data_valid, o_active_fx, o_timeout, o_data, fx_o_data);
        end
        quiet = 1'b1;
        for (int k = 0; k < 6; k++) begin
            fx_i_done = 3'b010;
            fx_i_data = {NFX{16'hffff}};
            tick();
            if (o_data_valid !== 1'b0 || fx_o_start !== '0 || o_read_enable !== 1'b0) quiet = 1'b0;
        end
        fx_i_done = '0;
        total++;
        if (!quiet) begin
            bad++;
            $display("FAIL reset_abort: aborted sample produced output or start after reset");
        end
        run_sample(2'd2, 16'h4321, 1, 3, 16'h8765, 1, 1, -1);
    endtask

    task automatic test_random();
        int delay;
        for (int n = 0; n < 24; n++) begin
            delay = ($urandom_range(0, 7) == 0) ? TO + 1 + $urandom_range(0, 4) : $urandom_range(1, 12);
            run_sample(2'($urandom_range(0, 3)), DW'($urandom), $urandom_range(0, 3), delay,
                       DW'($urandom), $urandom_range(0, 3), 1, 4);
        end
    endtask

    initial begin
        reset = 1'b1;
        sw = 2'd0;
        i_data_ready = 1'b0;
        i_data = '0;
        i_read_done = 1'b0;
        fx_i_done = '0;
        fx_i_data = '0;
        i_out_ready = 1'b0;

        test_reset();
        test_bypass();
        test_effect1();
        test_back_to_back();
        test_stray_done();
        test_sw_toggle();
        test_timeout();
        test_reset_in_wait();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
